// File: rtl/bus_test_sequencer.sv
// bus_test_sequencer: drives one command per transaction onto NUM_MASTERS bus master lanes.
// It drives for HOLD_CYCLES cycles, then waits (bounded by TIMEOUT) for the masters to drop
// their request lines, then pulses done and counts transactions that completed cleanly.
//
// Optional feature: define SEQ_BURST_EN to add burst_len_i. A transaction then runs
// burst_len_i+1 beats, and each masked lane's address increments by one per beat.
//
// Ports:
//   clk, reset        clock (rising edge); asynchronous active-high reset
//   start_i           launch request, sampled only in IDLE
//   cmd_mask_i        lanes taking part in the transaction
//   cmd_read_i        per lane: 1 = read, 0 = write
//   cmd_addr_i        per-lane address, lane i at [i*ADDR_W +: ADDR_W]
//   cmd_data_i        per-lane write data, lane i at [i*DATA_W +: DATA_W]
//   burst_len_i       beats minus one (SEQ_BURST_EN only)
//   m_request_i       per-master busy/request from the bus masters
//   m_enable_o        per-master transaction enable
//   m_read_en_o       per-master read enable
//   m_addr_o          per-master address
//   m_data_o          per-master data
//   busy_o            high whenever the state is not IDLE
//   done_o            one-cycle pulse at the end of a transaction
//   timeout_o         sticky abort flag, cleared by the next accepted start
//   txn_count_o       transactions completed without timeout, saturating
//   state_out_o       IDLE=0, DRIVE=1, WAIT=2, DONE=3
module bus_test_sequencer #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned HOLD_CYCLES = 3,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic [NUM_MASTERS-1:0]        cmd_mask_i,
  input  logic [NUM_MASTERS-1:0]        cmd_read_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] cmd_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] cmd_data_i,
`ifdef SEQ_BURST_EN
  input  logic [3:0]                    burst_len_i,
`endif
  input  logic [NUM_MASTERS-1:0]        m_request_i,
  output logic [NUM_MASTERS-1:0]        m_enable_o,
  output logic [NUM_MASTERS-1:0]        m_read_en_o,
  output logic [NUM_MASTERS*ADDR_W-1:0] m_addr_o,
  output logic [NUM_MASTERS*DATA_W-1:0] m_data_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          timeout_o,
  output logic [15:0]                   txn_count_o,
  output logic [1:0]                    state_out_o
);

  // The hold counter never exceeds HOLD_CYCLES-1.
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e                        state_q;
  logic [NUM_MASTERS-1:0]        mask_q;
  logic [HoldW-1:0]              hold_q;
  logic [WaitW-1:0]              wait_q;
  logic [3:0]                    burst_q;
  logic [NUM_MASTERS-1:0]        enable_q;
  logic [NUM_MASTERS-1:0]        read_en_q;
  logic [NUM_MASTERS*ADDR_W-1:0] addr_q;
  logic [NUM_MASTERS*DATA_W-1:0] data_q;
  logic                          busy_q;
  logic                          done_q;
  logic                          timeout_q;
  logic [15:0]                   count_q;

  logic [3:0]                    burst_len;
  logic [NUM_MASTERS*ADDR_W-1:0] masked_addr;
  logic [NUM_MASTERS*DATA_W-1:0] masked_data;
  logic [NUM_MASTERS*ADDR_W-1:0] next_beat_addr;
  logic                          released;

`ifdef SEQ_BURST_EN
  assign burst_len = burst_len_i;
`else
  // Single-beat build: the beat counter is tied off and optimises away.
  assign burst_len = 4'd0;
`endif

  assign released = ((m_request_i & mask_q) == '0);

  // Unmasked lanes are forced to zero; addresses wrap per lane on each new beat.
  always_comb begin
    masked_addr    = '0;
    masked_data    = '0;
    next_beat_addr = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (cmd_mask_i[i]) begin
        masked_addr[i*ADDR_W +: ADDR_W] = cmd_addr_i[i*ADDR_W +: ADDR_W];
        masked_data[i*DATA_W +: DATA_W] = cmd_data_i[i*DATA_W +: DATA_W];
      end
      if (mask_q[i]) begin
        next_beat_addr[i*ADDR_W +: ADDR_W] = addr_q[i*ADDR_W +: ADDR_W] + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      hold_q    <= '0;
      wait_q    <= '0;
      burst_q   <= '0;
      enable_q  <= '0;
      read_en_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i && (cmd_mask_i != '0)) begin
            state_q   <= StDrive;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
            mask_q    <= cmd_mask_i;
            enable_q  <= cmd_mask_i;
            read_en_q <= cmd_mask_i & cmd_read_i;
            addr_q    <= masked_addr;
            data_q    <= masked_data;
            burst_q   <= burst_len;
            hold_q    <= '0;
            wait_q    <= '0;
          end
        end
        StDrive: begin
          if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
            state_q  <= StWait;
            enable_q <= '0;
            hold_q   <= '0;
            wait_q   <= '0;
          end else begin
            hold_q <= hold_q + HoldW'(1);
          end
        end
        StWait: begin
          // Release is tested first so it wins over a coincident timeout.
          if (released && (burst_q != 4'd0)) begin
            state_q  <= StDrive;
            enable_q <= mask_q;
            addr_q   <= next_beat_addr;
            burst_q  <= burst_q - 4'd1;
            wait_q   <= '0;
          end else if (released || (wait_q == WaitW'(TIMEOUT - 1))) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            read_en_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wait_q    <= '0;
            burst_q   <= '0;
            if (!released) begin
              timeout_q <= 1'b1;
            end else if (count_q != 16'hFFFF) begin
              count_q <= count_q + 16'd1;
            end
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_enable_o  = enable_q;
  assign m_read_en_o = read_en_q;
  assign m_addr_o    = addr_q;
  assign m_data_o    = data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign txn_count_o = count_q;
  assign state_out_o = state_q;

endmodule
